// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
//   arb_state_t : arbiter FSM states
//   REQ_A2D     : requester index of the A2D interface
//   REQ_INERT   : requester index of the inertial sensor interface
//   DW          : SPI transfer word width
//   onehot2     : 1-bit requester index -> 2-bit one-hot grant vector
package spi_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} arb_state_t;

    localparam int REQ_A2D   = 0;
    localparam int REQ_INERT = 1;
    localparam int DW        = 16;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_arb_if.sv
// Bundle of the requester-side and SPI_mnrch-side signals of the arbiter.
//   slave  modport : the arbiter (takes requests and m_done/m_rd_data,
//                    drives grants, completions and the SPI_mnrch command)
//   master modport : the surroundings (requesters plus SPI_mnrch)
interface spi_arb_if;
    import spi_arb_pkg::*;

    logic [1:0]    r_wrt;
    logic [DW-1:0] r_wt_data0;
    logic [DW-1:0] r_wt_data1;
    logic [1:0]    r_lock;
    logic [1:0]    r_done;
    logic [DW-1:0] r_rd_data;
    logic [1:0]    gnt;
    logic [1:0]    ovf;
    logic          to_err;
    logic          m_wrt;
    logic [DW-1:0] m_wt_data;
    logic          m_done;
    logic [DW-1:0] m_rd_data;

    modport slave (
        input  r_wrt, r_wt_data0, r_wt_data1, r_lock, m_done, m_rd_data,
        output r_done, r_rd_data, gnt, ovf, to_err, m_wrt, m_wt_data
    );

    modport master (
        output r_wrt, r_wt_data0, r_wt_data1, r_lock, m_done, m_rd_data,
        input  r_done, r_rd_data, gnt, ovf, to_err, m_wrt, m_wt_data
    );

endinterface

// File: rtl/spi_req_slot.sv
// One requester's pending-request slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   wrt        : single-cycle transfer request
//   wt_data    : word to transmit, captured with wrt
//   clr        : arbiter has issued this slot's word (only when pend=1)
//   pend       : a captured word waits for the bus
//   pdata      : the captured word
//   ovf        : 1-clock pulse when wrt arrived while pend was already set
module spi_req_slot
    import spi_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wrt,
    input  logic [DW-1:0] wt_data,
    input  logic          clr,
    output logic          pend,
    output logic [DW-1:0] pdata,
    output logic          ovf
);

    logic          pend_reg;
    logic [DW-1:0] pdata_reg;
    logic          ovf_reg;

    // clr is only raised while pend_reg is set, so it never competes
    // with a capture in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg  <= 1'b0;
            pdata_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            ovf_reg <= wrt & pend_reg;
            if (wrt && !pend_reg) begin
                pend_reg  <= 1'b1;
                pdata_reg <= wt_data;
            end else if (clr) begin
                pend_reg <= 1'b0;
            end
        end
    end

    assign pend  = pend_reg;
    assign pdata = pdata_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/spi_arb.sv
// Arbiter sharing one SPI_mnrch master between the A2D interface
// (requester 0) and the inertial sensor interface (requester 1).
//   clk, rst_n : clock, asynchronous active-low reset (shared with SPI_mnrch)
//   bus        : requester handshakes (r_wrt, r_wt_data0/1, r_lock, r_done,
//                r_rd_data), status (gnt, ovf, to_err) and the SPI_mnrch
//                command/response (m_wrt, m_wt_data, m_done, m_rd_data)
// Round-robin between two pending requesters; an owner holding r_lock at
// m_done keeps the bus in HOLD until it issues again, drops the lock, or
// idles for HOLD_TO clocks.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int HOLD_TO = 64
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_arb_if.slave bus
);

    localparam int TW = $clog2(HOLD_TO + 1);

    arb_state_t    state_reg, state_next;
    logic          owner_reg, owner_next;
    logic          last_reg, last_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          m_wrt_reg, m_wrt_next;
    logic [DW-1:0] m_wt_data_reg, m_wt_data_next;
    logic          to_err_reg, to_err_next;

    logic [1:0]    pend;
    logic [1:0]    ovf;
    logic [1:0]    clr;
    logic [DW-1:0] wt_data [2];
    logic [DW-1:0] pdata [2];
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic          issue_en;
    logic          issue_idx;
    logic          winner;

    assign wt_data[REQ_A2D]   = bus.r_wt_data0;
    assign wt_data[REQ_INERT] = bus.r_wt_data1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            spi_req_slot u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .wrt     (bus.r_wrt[gi]),
                .wt_data (wt_data[gi]),
                .clr     (clr[gi]),
                .pend    (pend[gi]),
                .pdata   (pdata[gi]),
                .ovf     (ovf[gi])
            );
        end
    endgenerate

    // With both pending, the requester not served last wins.
    assign winner = (pend == 2'b11) ? ~last_reg : pend[1];

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;
        timer_next     = timer_reg;
        m_wrt_next     = 1'b0;
        m_wt_data_next = m_wt_data_reg;
        to_err_next    = 1'b0;
        gnt            = 2'b00;
        done           = 2'b00;
        issue_en       = 1'b0;
        issue_idx      = 1'b0;
        clr            = 2'b00;

        case (state_reg)
            IDLE: begin
                if (|pend) begin
                    issue_en  = 1'b1;
                    issue_idx = winner;
                end
            end
            BUSY: begin
                gnt = onehot2(owner_reg);
                if (bus.m_done) begin
                    done       = onehot2(owner_reg);
                    last_next  = owner_reg;
                    state_next = bus.r_lock[owner_reg] ? HOLD : IDLE;
                end
            end
            HOLD: begin
                gnt        = onehot2(owner_reg);
                timer_next = timer_reg + TW'(1);
                if (pend[owner_reg]) begin
                    // The locked owner goes first even if the other side waits.
                    issue_en   = 1'b1;
                    issue_idx  = owner_reg;
                    timer_next = '0;
                end else if (!bus.r_lock[owner_reg]) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer_reg == TW'(HOLD_TO - 1)) begin
                    state_next  = IDLE;
                    to_err_next = 1'b1;
                    timer_next  = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        if (issue_en) begin
            m_wrt_next     = 1'b1;
            m_wt_data_next = pdata[issue_idx];
            owner_next     = issue_idx;
            clr            = onehot2(issue_idx);
            state_next     = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            last_reg      <= 1'b0;
            timer_reg     <= '0;
            m_wrt_reg     <= 1'b0;
            m_wt_data_reg <= '0;
            to_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            timer_reg     <= timer_next;
            m_wrt_reg     <= m_wrt_next;
            m_wt_data_reg <= m_wt_data_next;
            to_err_reg    <= to_err_next;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.r_done    = done;
    assign bus.r_rd_data = bus.m_rd_data;
    assign bus.ovf       = ovf;
    assign bus.to_err    = to_err_reg;
    assign bus.m_wrt     = m_wrt_reg;
    assign bus.m_wt_data = m_wt_data_reg;

endmodule

// File: tb/tb_spi_arb.sv
module tb_spi_arb;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    spi_arb_if bus ();

    spi_arb #(.HOLD_TO(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.r_wrt      = 2'b00;
        bus.r_wt_data0 = 16'h0000;
        bus.r_wt_data1 = 16'h0000;
        bus.r_lock     = 2'b00;
        bus.m_done     = 1'b0;
        bus.m_rd_data  = 16'h0000;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt); end
        n_checks++;
        if (bus.m_wrt !== 1'b0) begin n_fail++; $display("FAIL reset_m_wrt: got %b expected 0", bus.m_wrt); end
        n_checks++;
        if (bus.m_wt_data !== 16'h0000) begin n_fail++; $display("FAIL reset_m_wt_data: got %h expected 0000", bus.m_wt_data); end
        n_checks++;
        if ({bus.r_done, bus.ovf, bus.to_err} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {bus.r_done, bus.ovf, bus.to_err}); end
        step();
        rst_n = 1'b1;
        step();
        $display("reset: outputs checked");
    endtask

    task automatic test_single();
        bus.r_wrt = 2'b01; bus.r_wt_data0 = 16'h2000;
        step();
        bus.r_wrt = 2'b00;
        n_checks++;
        if (bus.m_wrt !== 1'b0) begin n_fail++; $display("FAIL single_early: m_wrt got %b expected 0", bus.m_wrt); end
        step();
        n_checks++;
        if ({bus.m_wrt, bus.gnt, bus.m_wt_data} !== {1'b1, 2'b01, 16'h2000})
            begin n_fail++; $display("FAIL single_issue: m_wrt/gnt/data got %b %b %h expected 1 01 2000", bus.m_wrt, bus.gnt, bus.m_wt_data); end
        step();
        n_checks++;
        if ({bus.m_wrt, bus.gnt} !== {1'b0, 2'b01}) begin n_fail++; $display("FAIL single_pulse: m_wrt/gnt got %b %b expected 0 01", bus.m_wrt, bus.gnt); end
        repeat (27) step();
        bus.m_done = 1'b1; bus.m_rd_data = 16'h0ABC;
        #1;
        n_checks++;
        if ({bus.r_done, bus.r_rd_data} !== {2'b01, 16'h0ABC})
            begin n_fail++; $display("FAIL single_done: r_done/rd got %b %h expected 01 0abc", bus.r_done, bus.r_rd_data); end
        step();
        bus.m_done = 1'b0;
        n_checks++;
        if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL single_idle: gnt got %b expected 00", bus.gnt); end
        $display("single: req0 2000 -> rd 0abc");
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.r_wrt = 2'b11; bus.r_wt_data0 = 16'hA000; bus.r_wt_data1 = 16'hB111;
        step();
        bus.r_wrt = 2'b00;
        step();
        n_checks++;
        if ({bus.m_wrt, bus.gnt, bus.m_wt_data} !== {1'b1, 2'b10, 16'hB111})
            begin n_fail++; $display("FAIL rr_first: m_wrt/gnt/data got %b %b %h expected 1 10 b111", bus.m_wrt, bus.gnt, bus.m_wt_data); end
        repeat (3) step();
        bus.m_done = 1'b1;
        #1;
        n_checks++;
        if (bus.r_done !== 2'b10) begin n_fail++; $display("FAIL rr_done1: r_done got %b expected 10", bus.r_done); end
        step();
        bus.m_done = 1'b0;
        n_checks++;
        if ({bus.m_wrt, bus.gnt} !== {1'b0, 2'b00}) begin n_fail++; $display("FAIL rr_gap: m_wrt/gnt got %b %b expected 0 00", bus.m_wrt, bus.gnt); end
        step();
        n_checks++;
        if ({bus.m_wrt, bus.gnt, bus.m_wt_data} !== {1'b1, 2'b01, 16'hA000})
            begin n_fail++; $display("FAIL rr_second: m_wrt/gnt/data got %b %b %h expected 1 01 a000", bus.m_wrt, bus.gnt, bus.m_wt_data); end
        repeat (2) step();
        bus.m_done = 1'b1;
        #1;
        n_checks++;
        if (bus.r_done !== 2'b01) begin n_fail++; $display("FAIL rr_done0: r_done got %b expected 01", bus.r_done); end
        step();
        bus.m_done = 1'b0;
        // lone requester 1 transfer leaves last=1
        bus.r_wrt = 2'b10; bus.r_wt_data1 = 16'hC222;
        step();
        bus.r_wrt = 2'b00;
        step();
        n_checks++;
        if ({bus.m_wrt, bus.gnt, bus.m_wt_data} !== {1'b1, 2'b10, 16'hC222})
            begin n_fail++; $display("FAIL rr_lone: m_wrt/gnt/data got %b %b %h expected 1 10 c222", bus.m_wrt, bus.gnt, bus.m_wt_data); end
        step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        bus.r_wrt = 2'b11; bus.r_wt_data0 = 16'hD333; bus.r_wt_data1 = 16'hE444;
        step();
        bus.r_wrt = 2'b00;
        step();
        n_checks++;
        if ({bus.gnt, bus.m_wt_data} !== {2'b01, 16'hD333})
            begin n_fail++; $display("FAIL rr_repeat0: gnt/data got %b %h expected 01 d333", bus.gnt, bus.m_wt_data); end
        step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        step();
        n_checks++;
        if ({bus.gnt, bus.m_wt_data} !== {2'b10, 16'hE444})
            begin n_fail++; $display("FAIL rr_repeat1: gnt/data got %b %h expected 10 e444", bus.gnt, bus.m_wt_data); end
        step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        $display("round_robin: 1,0 then 1 alone, then 0,1");
    endtask

    task automatic test_lock();
        bus.r_lock = 2'b01;
        bus.r_wrt = 2'b01; bus.r_wt_data0 = 16'h2000;
        step();
        bus.r_wrt = 2'b10; bus.r_wt_data1 = 16'h8F00;
        step();
        bus.r_wrt = 2'b00;
        n_checks++;
        if ({bus.m_wrt, bus.gnt, bus.m_wt_data} !== {1'b1, 2'b01, 16'h2000})
            begin n_fail++; $display("FAIL lock_issue: m_wrt/gnt/data got %b %b %h expected 1 01 2000", bus.m_wrt, bus.gnt, bus.m_wt_data); end
        step();
        bus.m_done = 1'b1;
        #1;
        n_checks++;
        if (bus.r_done !== 2'b01) begin n_fail++; $display("FAIL lock_done1: r_done got %b expected 01", bus.r_done); end
        step();
        bus.m_done = 1'b0;
        n_checks++;
        if ({bus.m_wrt, bus.gnt} !== {1'b0, 2'b01}) begin n_fail++; $display("FAIL lock_hold: m_wrt/gnt got %b %b expected 0 01", bus.m_wrt, bus.gnt); end
        repeat (4) step();
        bus.r_wrt = 2'b01; bus.r_wt_data0 = 16'h1800;
        step();
        bus.r_wrt = 2'b00; bus.r_lock = 2'b00;
        n_checks++;
        if ({bus.m_wrt, bus.gnt} !== {1'b0, 2'b01}) begin n_fail++; $display("FAIL lock_wait: m_wrt/gnt got %b %b expected 0 01", bus.m_wrt, bus.gnt); end
        step();
        n_checks++;
        if ({bus.m_wrt, bus.gnt, bus.m_wt_data} !== {1'b1, 2'b01, 16'h1800})
            begin n_fail++; $display("FAIL lock_second: m_wrt/gnt/data got %b %b %h expected 1 01 1800", bus.m_wrt, bus.gnt, bus.m_wt_data); end
        step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        n_checks++;
        if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL lock_release: gnt got %b expected 00", bus.gnt); end
        step();
        n_checks++;
        if ({bus.m_wrt, bus.gnt, bus.m_wt_data} !== {1'b1, 2'b10, 16'h8F00})
            begin n_fail++; $display("FAIL lock_other: m_wrt/gnt/data got %b %b %h expected 1 10 8f00", bus.m_wrt, bus.gnt, bus.m_wt_data); end
        step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        $display("lock: req0 2000,1800 then req1 8f00");
    endtask

    task automatic test_timeout();
        bus.r_lock = 2'b01;
        bus.r_wrt = 2'b01; bus.r_wt_data0 = 16'h3000;
        step();
        bus.r_wrt = 2'b10; bus.r_wt_data1 = 16'h9100;
        step();
        bus.r_wrt = 2'b00;
        n_checks++;
        if ({bus.m_wrt, bus.gnt} !== {1'b1, 2'b01}) begin n_fail++; $display("FAIL to_issue: m_wrt/gnt got %b %b expected 1 01", bus.m_wrt, bus.gnt); end
        step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if ({bus.gnt, bus.to_err} !== {2'b01, 1'b0})
                begin n_fail++; $display("FAIL to_hold%0d: gnt/to_err got %b %b expected 01 0", k, bus.gnt, bus.to_err); end
            step();
        end
        n_checks++;
        if ({bus.gnt, bus.to_err} !== {2'b00, 1'b1})
            begin n_fail++; $display("FAIL to_pulse: gnt/to_err got %b %b expected 00 1", bus.gnt, bus.to_err); end
        bus.r_lock = 2'b00;
        step();
        n_checks++;
        if ({bus.to_err, bus.m_wrt, bus.gnt, bus.m_wt_data} !== {1'b0, 1'b1, 2'b10, 16'h9100})
            begin n_fail++; $display("FAIL to_next: to_err/m_wrt/gnt/data got %b %b %b %h expected 0 1 10 9100", bus.to_err, bus.m_wrt, bus.gnt, bus.m_wt_data); end
        step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        $display("timeout: hold 8 clocks, to_err, req1 9100");
    endtask

    task automatic test_overflow();
        bus.r_wrt = 2'b01; bus.r_wt_data0 = 16'h4000;
        step();
        bus.r_wrt = 2'b00;
        step();
        n_checks++;
        if ({bus.m_wrt, bus.gnt} !== {1'b1, 2'b01}) begin n_fail++; $display("FAIL ovf_issue: m_wrt/gnt got %b %b expected 1 01", bus.m_wrt, bus.gnt); end
        bus.r_wrt = 2'b10; bus.r_wt_data1 = 16'h5555;
        step();
        bus.r_wt_data1 = 16'h6666;
        n_checks++;
        if (bus.ovf !== 2'b00) begin n_fail++; $display("FAIL ovf_first: ovf got %b expected 00", bus.ovf); end
        step();
        bus.r_wrt = 2'b00;
        n_checks++;
        if (bus.ovf !== 2'b10) begin n_fail++; $display("FAIL ovf_pulse: ovf got %b expected 10", bus.ovf); end
        step();
        n_checks++;
        if (bus.ovf !== 2'b00) begin n_fail++; $display("FAIL ovf_clear: ovf got %b expected 00", bus.ovf); end
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        step();
        n_checks++;
        if ({bus.m_wrt, bus.gnt, bus.m_wt_data} !== {1'b1, 2'b10, 16'h5555})
            begin n_fail++; $display("FAIL ovf_word: m_wrt/gnt/data got %b %b %h expected 1 10 5555", bus.m_wrt, bus.gnt, bus.m_wt_data); end
        step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        $display("overflow: req1 second word dropped, 5555 sent");
    endtask

    task automatic test_reset_mid();
        bus.r_wrt = 2'b01; bus.r_wt_data0 = 16'h7777;
        step();
        bus.r_wrt = 2'b10; bus.r_wt_data1 = 16'h7A7A;
        step();
        bus.r_wrt = 2'b00;
        n_checks++;
        if ({bus.m_wrt, bus.gnt} !== {1'b1, 2'b01}) begin n_fail++; $display("FAIL rmid_issue: m_wrt/gnt got %b %b expected 1 01", bus.m_wrt, bus.gnt); end
        step();
        bus.m_done = 1'b1; bus.m_rd_data = 16'h1111;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.gnt, bus.m_wrt, bus.m_wt_data, bus.r_done} !== {2'b00, 1'b0, 16'h0000, 2'b00})
            begin n_fail++; $display("FAIL rmid_outputs: gnt/m_wrt/data/r_done got %b %b %h %b expected 00 0 0000 00", bus.gnt, bus.m_wrt, bus.m_wt_data, bus.r_done); end
        step();
        rst_n = 1'b1;
        bus.m_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if ({bus.m_wrt, bus.gnt} !== {1'b0, 2'b00})
                begin n_fail++; $display("FAIL rmid_idle%0d: m_wrt/gnt got %b %b expected 0 00", k, bus.m_wrt, bus.gnt); end
        end
        $display("reset_mid: transfer aborted, bus idle");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
